// File: rtl/modadd_ctrl.sv
// Two-pass modular add/subtract controller in front of a pipelined 1030-bit adder.
// Pass 1 forms a+b or a-b, pass 2 forms the corrective r1-m or r1+m, then the result is selected.
module modadd_ctrl #(
  parameter int ADD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [1023:0] in_a,
  input  logic [1023:0] in_b,
  input  logic [1023:0] in_m,
  output logic          busy,
  output logic          done,
  output logic [1023:0] result,
  output logic          add_subtract,
  output logic [1029:0] add_in_a,
  output logic [1029:0] add_in_b,
  input  logic [1030:0] add_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Each pass spans ADD_LAT+1 edges; the counter runs 0..ADD_LAT within a pass.
  localparam logic [2:0] LAST_CNT = 3'(ADD_LAT);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [1023:0] m_q, m_d;
  logic          r1_borrow_q, r1_borrow_d;
  logic [1023:0] r1_low_q, r1_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1023:0] result_q, result_d;
  logic          add_sub_q, add_sub_d;
  logic [1029:0] add_a_q, add_a_d;
  logic [1029:0] add_b_q, add_b_d;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    m_d         = m_q;
    r1_borrow_d = r1_borrow_q;
    r1_low_d    = r1_low_q;
    busy_d      = busy_q;
    done_d      = done_q;
    result_d    = result_q;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;

    case (state_q)
      IDLE: begin
        cnt_d  = 3'd0;
        done_d = 1'b0;
        if (start) begin
          op_d      = op;
          m_d       = in_m;
          add_a_d   = {6'b0, in_a};
          add_b_d   = {6'b0, in_b};
          add_sub_d = op;
          busy_d    = 1'b1;
          state_d   = P1;
        end else begin
          busy_d = 1'b0;
        end
      end
      P1: begin
        if (cnt_q == LAST_CNT) begin
          r1_borrow_d = add_result[1030];
          r1_low_d    = add_result[1023:0];
          add_a_d     = add_result[1029:0];
          add_b_d     = {6'b0, m_q};
          add_sub_d   = ~op_q;
          cnt_d       = 3'd0;
          state_d     = P2;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      P2: begin
        if (cnt_q == LAST_CNT) begin
          // add_result is r2 here: add keeps r1 when r1-m borrowed, sub takes r1+m when a-b borrowed.
          if (op_q) begin
            result_d = r1_borrow_q ? add_result[1023:0] : r1_low_q;
          end else begin
            result_d = add_result[1030] ? r1_low_q : add_result[1023:0];
          end
          add_a_d   = 1030'd0;
          add_b_d   = 1030'd0;
          add_sub_d = 1'b0;
          done_d    = 1'b1;
          cnt_d     = 3'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        add_a_d   = 1030'd0;
        add_b_d   = 1030'd0;
        add_sub_d = 1'b0;
        cnt_d     = 3'd0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      op_q        <= 1'b0;
      m_q         <= 1024'd0;
      r1_borrow_q <= 1'b0;
      r1_low_q    <= 1024'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1024'd0;
      add_sub_q   <= 1'b0;
      add_a_q     <= 1030'd0;
      add_b_q     <= 1030'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      m_q         <= m_d;
      r1_borrow_q <= r1_borrow_d;
      r1_low_q    <= r1_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign add_subtract = add_sub_q;
  assign add_in_a     = add_a_q;
  assign add_in_b     = add_b_q;

endmodule

// File: tb/tb_modadd_ctrl.sv
// Bench for modadd_ctrl: ADD_LAT=1 and ADD_LAT=3 instances, each fed by a behavioural pipelined adder,
// with expected results taken from plain modular arithmetic.
module tb_modadd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          op;
  logic          start1, start3;
  logic [1023:0] in_a, in_b, in_m;

  logic          busy1, done1, sub1;
  logic [1023:0] res1;
  logic [1029:0] aa1, ab1;
  logic [1030:0] ar1;

  logic          busy3, done3, sub3;
  logic [1023:0] res3;
  logic [1029:0] aa3, ab3;
  logic [1030:0] ar3;
  logic [1030:0] p3 [3];

  int checks   = 0;
  int failures = 0;

  modadd_ctrl #(.ADD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy1), .done(done1), .result(res1),
    .add_subtract(sub1), .add_in_a(aa1), .add_in_b(ab1), .add_result(ar1)
  );

  modadd_ctrl #(.ADD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .op(op),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy3), .done(done3), .result(res3),
    .add_subtract(sub3), .add_in_a(aa3), .add_in_b(ab3), .add_result(ar3)
  );

  // Adder behaviour: bit 1030 is carry for add and borrow for subtract.
  function automatic logic [1030:0] adder(input logic [1029:0] x, input logic [1029:0] y, input logic s);
    if (s) return {1'b0, x} - {1'b0, y};
    else   return {1'b0, x} + {1'b0, y};
  endfunction

  always @(posedge clk) ar1 <= adder(aa1, ab1, sub1);

  always @(posedge clk) begin
    p3[0] <= adder(aa3, ab3, sub3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ar3 = p3[2];

  // Reference: (a+b) mod m or (a-b) mod m, valid for a<m, b<m, m!=0.
  function automatic logic [1023:0] ref_mod(input logic o, input logic [1023:0] a,
                                            input logic [1023:0] b, input logic [1023:0] m);
    logic [1025:0] x;
    if (!o) x = ({2'b0, a} + {2'b0, b}) % {2'b0, m};
    else    x = ({2'b0, a} + {2'b0, m} - {2'b0, b}) % {2'b0, m};
    return x[1023:0];
  endfunction

  function automatic logic [1029:0] ref_r1(input logic o, input logic [1023:0] a, input logic [1023:0] b);
    if (o) return {6'b0, a} - {6'b0, b};
    else   return {6'b0, a} + {6'b0, b};
  endfunction

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic rand_ops(output logic o, output logic [1023:0] a, output logic [1023:0] b,
                          output logic [1023:0] m);
    o = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) m = 1024'($urandom_range(1, 1000));
    else m = rand1024();
    if (m == 1024'd0) m = 1024'd1;
    a = rand1024() % m;
    b = rand1024() % m;
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // Start one ADD_LAT=1 operation; returns edges from acceptance to done (-1 if never), ends in the done cycle.
  task automatic run1(input logic o, input logic [1023:0] a, input logic [1023:0] b,
                      input logic [1023:0] m, output int lat);
    op = o; in_a = a; in_b = b; in_m = m; start1 = 1'b1;
    wait_clk();
    start1 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      wait_clk();
      if (done1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b1; start3 = 1'b1; op = 1'b1;
    in_a = 1024'd3; in_b = 1024'd5; in_m = 1024'd11;
    wait_clk();
    wait_clk();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 1024'd0 || aa1 !== 1030'd0 || ab1 !== 1030'd0 || sub1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat1: busy=%b done=%b sub=%b res_nz=%b", busy1, done1, sub1, res1 != 1024'd0);
    end
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || res3 !== 1024'd0 || aa3 !== 1030'd0 || ab3 !== 1030'd0 || sub3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat3: busy=%b done=%b sub=%b res_nz=%b", busy3, done3, sub3, res3 != 1024'd0);
    end
    start1 = 1'b0; start3 = 1'b0; reset = 1'b0;
    wait_clk();
    checks++;
    if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept: busy1=%b busy3=%b required 0", busy1, busy3);
    end
  endtask

  task automatic test_directed();
    logic          vo [5];
    logic [1023:0] va [5], vb [5], vm [5];
    logic [1023:0] big, exp_r;
    int lat;
    big = '1;
    vo[0] = 1'b0; va[0] = 1024'd5;  vb[0] = 1024'd7;  vm[0] = 1024'd11;
    vo[1] = 1'b0; va[1] = 1024'd3;  vb[1] = 1024'd4;  vm[1] = 1024'd11;
    vo[2] = 1'b0; va[2] = big - 1024'd1; vb[2] = big - 1024'd1; vm[2] = big;
    vo[3] = 1'b1; va[3] = 1024'd3;  vb[3] = 1024'd5;  vm[3] = 1024'd11;
    vo[4] = 1'b1; va[4] = 1024'd7;  vb[4] = 1024'd7;  vm[4] = 1024'd11;
    for (int i = 0; i < 5; i++) begin
      exp_r = ref_mod(vo[i], va[i], vb[i], vm[i]);
      run1(vo[i], va[i], vb[i], vm[i], lat);
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got %0d required 4", i, lat);
      end
      checks++;
      if (res1 !== exp_r || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL directed_result[%0d]: got %h busy=%b required %h", i, res1[31:0], busy1, exp_r[31:0]);
      end
      wait_clk();
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL directed_after_done[%0d]: busy=%b done=%b required 0 0", i, busy1, done1);
      end
    end
  endtask

  task automatic test_pass_drive();
    logic o;
    logic [1023:0] a, b, m;
    logic [1029:0] r1;
    for (int i = 0; i < 4; i++) begin
      rand_ops(o, a, b, m);
      if (i < 2) o = 1'(i);
      r1 = ref_r1(o, a, b);
      op = o; in_a = a; in_b = b; in_m = m; start1 = 1'b1;
      wait_clk();
      start1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || aa1 !== {6'b0, a} || ab1 !== {6'b0, b} || sub1 !== o) begin
          failures++;
          $display("FAIL pass1_drive[%0d.%0d]: busy=%b sub=%b required sub=%b", i, k, busy1, sub1, o);
        end
        wait_clk();
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (aa1 !== r1 || ab1 !== {6'b0, m} || sub1 !== ~o || done1 !== 1'b0) begin
          failures++;
          $display("FAIL pass2_drive[%0d.%0d]: a_hi=%h sub=%b required a_hi=%h sub=%b", i, k,
                   aa1[1029:1024], sub1, r1[1029:1024], ~o);
        end
        wait_clk();
      end
      checks++;
      if (done1 !== 1'b1 || aa1 !== 1030'd0 || ab1 !== 1030'd0 || sub1 !== 1'b0 || res1 !== ref_mod(o, a, b, m)) begin
        failures++;
        $display("FAIL done_drive[%0d]: done=%b sub=%b res=%h required 1 0 %h", i, done1, sub1,
                 res1[31:0], ref_mod(o, a, b, m) & 1024'hffffffff);
      end
      wait_clk();
    end
  endtask

  task automatic test_random();
    logic o;
    logic [1023:0] a, b, m;
    int lat;
    for (int i = 0; i < 24; i++) begin
      rand_ops(o, a, b, m);
      run1(o, a, b, m, lat);
      checks++;
      if (lat !== 4 || res1 !== ref_mod(o, a, b, m)) begin
        failures++;
        $display("FAIL random[%0d]: op=%b lat=%0d res=%h required lat=4 res=%h", i, o, lat,
                 res1[31:0], ref_mod(o, a, b, m) & 1024'hffffffff);
      end
      wait_clk();
    end
  endtask

  task automatic test_ignore_start();
    logic o;
    logic [1023:0] a, b, m, got;
    int nd;
    rand_ops(o, a, b, m);
    op = o; in_a = a; in_b = b; in_m = m; start1 = 1'b1;
    wait_clk();
    start1 = 1'b0;
    wait_clk();
    wait_clk();
    op = ~o; in_a = b; in_b = a; in_m = m + 1024'd1; start1 = 1'b1;
    wait_clk();
    start1 = 1'b0;
    nd = 0;
    got = 1024'd0;
    for (int k = 0; k < 12; k++) begin
      if (done1) begin
        nd++;
        got = res1;
      end
      wait_clk();
    end
    checks++;
    if (nd !== 1 || got !== ref_mod(o, a, b, m) || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start: dones=%0d busy=%b res=%h required 1 0 %h", nd, busy1, got[31:0],
               ref_mod(o, a, b, m) & 1024'hffffffff);
    end
  endtask

  task automatic test_back_to_back();
    logic o1, o2;
    logic [1023:0] a1, b1, m1, a2, b2, m2;
    int lat;
    rand_ops(o1, a1, b1, m1);
    rand_ops(o2, a2, b2, m2);
    run1(o1, a1, b1, m1, lat);
    checks++;
    if (lat !== 4 || res1 !== ref_mod(o1, a1, b1, m1)) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d required 4", lat);
    end
    wait_clk();
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_busy: got %b required 0", busy1);
    end
    run1(o2, a2, b2, m2, lat);
    checks++;
    if (lat !== 4 || res1 !== ref_mod(o2, a2, b2, m2)) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d res=%h required lat=4 res=%h", lat, res1[31:0],
               ref_mod(o2, a2, b2, m2) & 1024'hffffffff);
    end
    wait_clk();
  endtask

  task automatic test_reset_abort();
    logic o;
    logic [1023:0] a, b, m;
    int lat, nd;
    rand_ops(o, a, b, m);
    op = o; in_a = a; in_b = b; in_m = m; start1 = 1'b1;
    wait_clk();
    start1 = 1'b0;
    wait_clk();
    wait_clk();
    reset = 1'b1;
    wait_clk();
    reset = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 1024'd0 || aa1 !== 1030'd0 || ab1 !== 1030'd0 || sub1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b sub=%b res_nz=%b", busy1, done1, sub1, res1 != 1024'd0);
    end
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      wait_clk();
      if (done1) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", nd);
    end
    rand_ops(o, a, b, m);
    run1(o, a, b, m, lat);
    checks++;
    if (lat !== 4 || res1 !== ref_mod(o, a, b, m)) begin
      failures++;
      $display("FAIL abort_rerun: lat=%0d required 4", lat);
    end
    wait_clk();
  endtask

  task automatic test_lat3_run(input logic o, input logic [1023:0] a, input logic [1023:0] b,
                               input logic [1023:0] m);
    logic [1029:0] r1;
    int lat, nd;
    r1 = ref_r1(o, a, b);
    op = o; in_a = a; in_b = b; in_m = m; start3 = 1'b1;
    wait_clk();
    start3 = 1'b0;
    lat = -1;
    nd = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) wait_clk();
      if (done3) begin
        nd++;
        if (lat < 0) lat = k;
      end
      if (k <= 3) begin
        checks++;
        if (aa3 !== {6'b0, a} || ab3 !== {6'b0, b} || sub3 !== o || busy3 !== 1'b1) begin
          failures++;
          $display("FAIL lat3_pass1[%0d]: sub=%b busy=%b required %b 1", k, sub3, busy3, o);
        end
      end else if (k <= 7) begin
        checks++;
        if (aa3 !== r1 || ab3 !== {6'b0, m} || sub3 !== ~o || busy3 !== 1'b1) begin
          failures++;
          $display("FAIL lat3_pass2[%0d]: sub=%b busy=%b required %b 1", k, sub3, busy3, ~o);
        end
      end else if (k == 8) begin
        checks++;
        if (aa3 !== 1030'd0 || ab3 !== 1030'd0 || sub3 !== 1'b0 || res3 !== ref_mod(o, a, b, m)) begin
          failures++;
          $display("FAIL lat3_done[%0d]: res=%h required %h", k, res3[31:0], ref_mod(o, a, b, m) & 1024'hffffffff);
        end
      end
    end
    checks++;
    if (lat !== 8 || nd !== 1 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL lat3_latency: lat=%0d dones=%0d busy=%b required 8 1 0", lat, nd, busy3);
    end
  endtask

  task automatic test_lat3();
    logic o;
    logic [1023:0] a, b, m;
    test_lat3_run(1'b1, 1024'd0, 1024'd1, 1024'd2);
    rand_ops(o, a, b, m);
    test_lat3_run(o, a, b, m);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; op = 1'b0;
    in_a = 1024'd0; in_b = 1024'd0; in_m = 1024'd0;
    test_reset();
    test_directed();
    test_pass_drive();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modadd_ctrl.md
MODADD_CTRL -- requirements
Module: modadd_ctrl

Interface
REQ-001 Parameter ADD_LAT, default 1: clock edges from the adder sampling its operands to add_result being valid; legal range 1..4.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request; sampled only in IDLE.
REQ-005 op  input  1  0 = modular add (a+b mod m), 1 = modular subtract (a-b mod m); sampled with start.
REQ-006 in_a, in_b, in_m  input  1024 each  operands and modulus; sampled with start.
REQ-007 busy  output  1  high from the edge that accepts start until done deasserts.
REQ-008 done  output  1  one-cycle pulse; result valid while done is high.
REQ-009 result  output  1024  modular result; holds its value until the next accepted start or reset.
REQ-010 add_subtract  output  1  to the pipelined adder: 0 add, 1 subtract (adder computes a + ~b + 1).
REQ-011 add_in_a, add_in_b  output  1030 each  adder operands; 1024-bit values zero-extended.
REQ-012 add_result  input  1031  adder output; bit 1030 = carry for add, borrow for subtract.

Function
REQ-013 The FSM SHALL use the states IDLE, P1 (drive pass 1, count ADD_LAT+1 edges), P2 (drive pass 2, count ADD_LAT+1 edges) and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op, in_a, in_b and in_m, load the pass-1 drive registers, and enter P1.
REQ-015 Pass 1 SHALL drive add_in_a={6'b0,a}, add_in_b={6'b0,b}, add_subtract=op, and SHALL hold them stable for the whole of P1.
REQ-016 On the last P1 edge (edge ADD_LAT+1 after acceptance), the block SHALL capture r1=add_result and enter P2.
REQ-017 Pass 2 SHALL drive add_in_a=r1[1029:0], add_in_b={6'b0,m}, and add_subtract=~op (add: r1-m; sub: r1+m).
REQ-018 On the last P2 edge (edge 2*ADD_LAT+2 after acceptance), the block SHALL capture r2, register result, and enter DONE.
REQ-019 Add selection: result = r1[1023:0] if r2[1030]=1 (borrow, a+b<m), else r2[1023:0].
REQ-020 Subtract selection: result = r2[1023:0] if r1[1030]=1 (borrow, a<b), else r1[1023:0].
REQ-021 Both passes SHALL always execute, so latency is fixed: done is high in the cycle after edge 2*ADD_LAT+2 following acceptance (4 cycles for ADD_LAT=1).
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE; busy SHALL be low in that next cycle.
REQ-023 start SHALL be ignored in P1, P2 and DONE; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-024 In IDLE and DONE, add_in_a, add_in_b and add_subtract SHALL be driven to 0.
REQ-025 Preconditions are a<m, b<m and m!=0. Outside them, the output SHALL follow REQ-019/020 exactly, with no other guarantee.
REQ-026 Pass-1 add SHALL NOT overflow 1025 bits; bits 1029:1025 of r1 SHALL be zero for add and sign-filled (all ones) for a subtract with borrow.

Reset
REQ-027 While reset is high, the state SHALL be IDLE and busy, done, result, add_in_a, add_in_b, add_subtract, r1 and r2 SHALL all be 0.
REQ-028 Reset asserted in any state SHALL abort the operation on that edge, with no done pulse. start SHALL NOT be accepted on an edge where reset is high.

Verification
REQ-029 ADD_LAT=1, op=0, a=5, b=7, m=11 -> done 4 cycles after start, result=1.
REQ-030 op=0, a=3, b=4, m=11 -> result=7. op=0, a=b=m-1, m=2^1024-1 -> result=2^1024-3.
REQ-031 op=1, a=3, b=5, m=11 -> result=9. op=1, a=7, b=7, m=11 -> result=0 (r1=0, no borrow).
REQ-032 start pulsed again 2 cycles after acceptance -> ignored; exactly one done; result from the first operands. Back-to-back start right after done -> accepted.
REQ-033 reset asserted in P2 -> next cycle all outputs 0 and no done. The following start runs the full latency with a correct result.
REQ-034 ADD_LAT=3, using an adder model with 3-cycle latency, op=1, a=0, b=1, m=2 -> done 8 cycles after start, result=1. Adder ports stay stable throughout each pass.
